gan_dense_engine: RTL and testbench

- Parametrised, time-multiplexed dense-layer engine for the GAN datapath: one shared signed multiply-accumulate computes every neuron of one fully connected layer in turn.
- x, w and b are loaded through a flat address/write-enable port, the same way as the existing GAN blocks.
- Layer size, arithmetic shift and ReLU are set at run time; results stream out one neuron at a time with a valid strobe.
- Supersedes the fixed-topology GAN blocks as the reusable layer building block.

---
 rtl/gan_dense_engine.sv | 171 +++++++++++++++++
 tb/tb_gan_dense_engine.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/gan_dense_engine.sv
// Time-multiplexed fully connected layer: one signed MAC walks every neuron, results stream out per neuron.
// Latency: neuron j valid (j+1)*(n_in+1) cycles after start; done one cycle after the last result.
// Backpressure: none; results are strobed, and writes or start while busy are dropped.
module gan_dense_engine #(
    parameter int WIDTH   = 28,
    parameter int MAX_IN  = 4,
    parameter int MAX_OUT = 4,
    parameter int ADDR_W  = 8,
    localparam int NI_W   = $clog2(MAX_IN + 1),
    localparam int NO_W   = $clog2(MAX_OUT + 1),
    localparam int IDX_W  = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [ADDR_W-1:0]       addr,
    input  logic signed [WIDTH-1:0] data_in,
    input  logic                    start,
    input  logic [NI_W-1:0]         n_in,
    input  logic [NO_W-1:0]         n_out,
    input  logic [4:0]              shift,
    input  logic                    relu_en,
    output logic signed [WIDTH-1:0] data_out,
    output logic                    data_valid,
    output logic [IDX_W-1:0]        out_idx,
    output logic                    sat,
    output logic                    busy,
    output logic                    done
);
    localparam int KW     = (MAX_IN > 1) ? $clog2(MAX_IN) : 1;
    localparam int ACC_W  = 2*WIDTH + $clog2(MAX_IN) + 1;
    localparam int W_BASE = MAX_IN;
    localparam int B_BASE = MAX_IN + MAX_OUT*MAX_IN;
    localparam int TOP    = B_BASE + MAX_OUT;
    localparam logic signed [ACC_W-1:0] SMAX = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SMIN = ~SMAX;

    typedef enum logic [1:0] {IDLE, MAC, OUT, FIN} state_t;

    logic signed [WIDTH-1:0] x_mem [MAX_IN];
    logic signed [WIDTH-1:0] w_mem [MAX_OUT][MAX_IN];
    logic signed [WIDTH-1:0] b_mem [MAX_OUT];

    // One extra address bit so the range compares stay correct when TOP == 2^ADDR_W.
    logic [ADDR_W:0]  addr_x, w_off;
    logic [KW-1:0]    x_idx, w_col;
    logic [IDX_W-1:0] w_row, b_idx;

    assign addr_x = {1'b0, addr};
    assign w_off  = addr_x - (ADDR_W+1)'(W_BASE);
    assign x_idx  = KW'(addr);
    assign w_row  = IDX_W'(w_off / (ADDR_W+1)'(MAX_IN));
    assign w_col  = KW'(w_off % (ADDR_W+1)'(MAX_IN));
    assign b_idx  = IDX_W'(addr_x - (ADDR_W+1)'(B_BASE));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < MAX_IN; i++) x_mem[i] <= '0;
            for (int i = 0; i < MAX_OUT; i++) begin
                b_mem[i] <= '0;
                for (int n = 0; n < MAX_IN; n++) w_mem[i][n] <= '0;
            end
        end else if (we && !busy) begin
            if (addr_x < (ADDR_W+1)'(W_BASE))
                x_mem[x_idx] <= data_in;
            else if (addr_x < (ADDR_W+1)'(B_BASE))
                w_mem[w_row][w_col] <= data_in;
            else if (addr_x < (ADDR_W+1)'(TOP))
                b_mem[b_idx] <= data_in;
        end
    end

    state_t                  state;
    logic [NI_W-1:0]         n_in_l, n_in_c;
    logic [NO_W-1:0]         n_out_l, n_out_c;
    logic [4:0]              shift_l;
    logic                    relu_l;
    logic [KW-1:0]           k;
    logic [IDX_W-1:0]        j, j_nxt;
    logic signed [ACC_W-1:0] acc, shr;
    logic signed [2*WIDTH-1:0] prod;
    logic signed [WIDTH-1:0] res;
    logic                    sat_c, last_k, last_j;

    assign n_in_c  = (n_in  > NI_W'(MAX_IN))  ? NI_W'(MAX_IN)  : n_in;
    assign n_out_c = (n_out > NO_W'(MAX_OUT)) ? NO_W'(MAX_OUT) : n_out;
    assign prod    = x_mem[k] * w_mem[j][k];
    assign j_nxt   = j + IDX_W'(1);
    assign last_k  = (NI_W'(k) == n_in_l - NI_W'(1));
    assign last_j  = (NO_W'(j) == n_out_l - NO_W'(1));

    always_comb begin
        shr = acc >>> shift_l;
        if (relu_l && shr[ACC_W-1])
            shr = '0;
        res   = shr[WIDTH-1:0];
        sat_c = 1'b0;
        if (shr > SMAX) begin
            res   = SMAX[WIDTH-1:0];
            sat_c = 1'b1;
        end else if (shr < SMIN) begin
            res   = SMIN[WIDTH-1:0];
            sat_c = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            n_in_l     <= '0;
            n_out_l    <= '0;
            shift_l    <= '0;
            relu_l     <= 1'b0;
            k          <= '0;
            j          <= '0;
            acc        <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            out_idx    <= '0;
            sat        <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            sat        <= 1'b0;
            done       <= 1'b0;
            unique case (state)
                IDLE: if (start) begin
                    n_in_l  <= n_in_c;
                    n_out_l <= n_out_c;
                    shift_l <= shift;
                    relu_l  <= relu_en;
                    if (n_out_c == '0) begin
                        state <= FIN;
                    end else begin
                        j     <= '0;
                        k     <= '0;
                        acc   <= ACC_W'(b_mem[0]);
                        busy  <= 1'b1;
                        state <= (n_in_c == '0) ? OUT : MAC;
                    end
                end
                MAC: begin
                    acc <= acc + ACC_W'(prod);
                    if (last_k) state <= OUT;
                    else        k     <= k + KW'(1);
                end
                OUT: begin
                    data_out   <= res;
                    out_idx    <= j;
                    sat        <= sat_c;
                    data_valid <= 1'b1;
                    if (last_j) begin
                        state <= FIN;
                    end else begin
                        j     <= j_nxt;
                        k     <= '0;
                        acc   <= ACC_W'(b_mem[j_nxt]);
                        state <= (n_in_l == '0) ? OUT : MAC;
                    end
                end
                FIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gan_dense_engine.sv
// Directed bench for gan_dense_engine: stimulus pushes expected results, a negedge monitor pops and compares.
module tb_gan_dense_engine;
    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               we = 1'b0;
    logic [7:0]         addr = '0;
    logic signed [27:0] data_in = '0;
    logic               start = 1'b0;
    logic [2:0]         n_in = '0;
    logic [2:0]         n_out = '0;
    logic [4:0]         shift = '0;
    logic               relu_en = 1'b0;
    logic signed [27:0] data_out;
    logic               data_valid;
    logic [1:0]         out_idx;
    logic               sat;
    logic               busy;
    logic               done;

    gan_dense_engine #(.WIDTH(28), .MAX_IN(4), .MAX_OUT(4), .ADDR_W(8)) dut (
        .clk(clk), .rst(rst), .we(we), .addr(addr), .data_in(data_in),
        .start(start), .n_in(n_in), .n_out(n_out), .shift(shift), .relu_en(relu_en),
        .data_out(data_out), .data_valid(data_valid), .out_idx(out_idx), .sat(sat),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_pass = 0;

    typedef struct {
        int d;
        int idx;
        bit s;
        int c;
    } exp_t;

    exp_t exq[$];
    int   dq[$];
    int   ev[4];
    bit   es[4];

    task automatic check(input string name, input longint act, input longint req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    endtask

    always @(negedge clk) begin
        if (data_valid) begin
            if (exq.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                exp_t e;
                e = exq.pop_front();
                check("data_out", data_out, e.d);
                check("out_idx", out_idx, e.idx);
                check("sat", sat, e.s);
                check("valid_cycle", cyc, e.c);
            end
        end
        if (done) begin
            if (dq.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                int c;
                c = dq.pop_front();
                check("done_cycle", cyc, c);
            end
        end
    end

    task automatic wr(input int a, input int d);
        @(negedge clk);
        we = 1'b1;
        addr = 8'(a);
        data_in = 28'(d);
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic load_basic();
        int xv[4]  = '{0, 1, 1, 0};
        int wv[16] = '{6, -3, 5, -16, 21, 16, -6, -9, 3, -3, -15, -17, 18, 12, -4, -8};
        int bv[4]  = '{1, 0, 2, -1};
        for (int i = 0; i < 4; i++) wr(i, xv[i]);
        for (int i = 0; i < 16; i++) wr(4 + i, wv[i]);
        for (int i = 0; i < 4; i++) wr(20 + i, bv[i]);
    endtask

    // mode: 0 plain, 1 extra start mid-run, 2 write x[1] mid-run, 3 reset at cycle 8
    task automatic go(input int nin, input int nout, input int sh, input bit relu, input int mode);
        int ne, no, t0, guard;
        exp_t e;
        ne = (nin > 4) ? 4 : nin;
        no = (nout > 4) ? 4 : nout;
        @(negedge clk);
        n_in = 3'(nin);
        n_out = 3'(nout);
        shift = 5'(sh);
        relu_en = relu;
        start = 1'b1;
        t0 = cyc + 1;
        for (int j = 0; j < no; j++) begin
            e.d = ev[j];
            e.idx = j;
            e.s = es[j];
            e.c = t0 + (j + 1) * (ne + 1);
            exq.push_back(e);
        end
        dq.push_back(t0 + no * (ne + 1) + 1);
        @(negedge clk);
        start = 1'b0;
        n_in = 3'd1;
        n_out = 3'd1;
        shift = 5'd3;
        relu_en = ~relu;
        if (no > 0) check("busy_run", busy, 1);
        if (mode == 1) begin
            repeat (5) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end else if (mode == 2) begin
            repeat (2) @(negedge clk);
            we = 1'b1;
            addr = 8'd1;
            data_in = 28'sd50;
            @(negedge clk);
            we = 1'b0;
        end else if (mode == 3) begin
            while (cyc < t0 + 8) @(negedge clk);
            rst = 1'b0;
            #1;
            check("rst_data_out", data_out, 0);
            check("rst_valid", data_valid, 0);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            exq.delete();
            dq.delete();
            repeat (3) @(negedge clk);
            rst = 1'b1;
            repeat (30) @(negedge clk);
            check("rst_quiet_busy", busy, 0);
            return;
        end
        guard = 0;
        while ((exq.size() + dq.size()) != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("run_complete", exq.size() + dq.size(), 0);
        check("busy_idle", busy, 0);
        exq.delete();
        dq.delete();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: global time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_data_out", data_out, 0);
        check("reset_valid", data_valid, 0);
        check("reset_out_idx", out_idx, 0);
        check("reset_sat", sat, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        rst = 1'b1;
        @(negedge clk);
        load_basic();

        ev = '{3, 10, -16, 7};
        es = '{0, 0, 0, 0};
        go(4, 4, 0, 1'b0, 0);
        ev = '{3, 10, 0, 7};
        go(4, 4, 0, 1'b1, 0);
        ev = '{1, 0, 0, 0};
        go(0, 2, 0, 1'b0, 0);
        go(4, 0, 0, 1'b0, 0);
        ev = '{3, 10, -16, 7};
        go(7, 4, 0, 1'b0, 0);
        go(4, 4, 0, 1'b0, 1);
        go(4, 4, 0, 1'b0, 2);
        go(4, 4, 0, 1'b0, 0);
        go(4, 4, 0, 1'b0, 3);

        load_basic();
        go(4, 4, 0, 1'b0, 0);

        wr(0, 100000);
        wr(4, 100000);
        wr(20, 0);
        ev[0] = 134217727;
        es[0] = 1'b1;
        go(1, 1, 0, 1'b0, 0);
        ev[0] = 39062500;
        es[0] = 1'b0;
        go(1, 1, 8, 1'b0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
